// File: rtl/keypad_scanner_if.sv
// Keypad matrix signals between the scanner and the pad / its driver.
// Row inputs are active-low; column drives are active-low one-cold.
interface keypad_scanner_if;
    logic [3:0] row_n;
    logic [2:0] col_n;
    logic [3:0] key_code;
    logic       key_held;

    modport master (
        output row_n,
        input  col_n,
        input  key_code,
        input  key_held
    );

    modport slave (
        input  row_n,
        output col_n,
        output key_code,
        output key_held
    );
endinterface

// File: rtl/keypad_scanner.sv
// 4x3 keypad scanner: column scan, 2-flop row sync, per-scan debounce,
// single-cycle key-code emission with press/release tracking.
module keypad_scanner #(
    parameter int SCAN_DIV       = 16,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic             clk,
    input  logic             rst,
    keypad_scanner_if.slave  kp
);
    localparam int SW = $clog2(SCAN_DIV);
    localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [3:0] NONE  = 4'd13;
    localparam logic [3:0] MULTI = 4'd15;

    typedef enum logic {IDLE, PRESSED} state_t;

    state_t          state_q, state_d;
    logic [3:0]      sync1_q, sync2_q;
    logic [SW-1:0]   slot_q;
    logic [1:0]      col_q;
    logic [11:0]     hits_q, hits_d, hits_now;
    logic [3:0]      cand_q, cand_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [3:0]      code_q, code_d;
    logic            slot_last, scan_done, stable;
    logic [3:0]      pop, idx, result;

    function automatic logic [3:0] code_of(input logic [3:0] i);
        case (i)
            4'd9:    code_of = 4'd11;
            4'd10:   code_of = 4'd0;
            4'd11:   code_of = 4'd10;
            default: code_of = i + 4'd1;
        endcase
    endfunction

    assign slot_last = (slot_q == SW'(SCAN_DIV - 1));
    assign scan_done = slot_last && (col_q == 2'd2);

    // Bring the asynchronous rows into the clock domain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 4'hF;
            sync2_q <= 4'hF;
        end else begin
            sync1_q <= kp.row_n;
            sync2_q <= sync1_q;
        end
    end

    // Slot counter and column index for the scan.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_q <= '0;
            col_q  <= '0;
        end else if (slot_last) begin
            slot_q <= '0;
            col_q  <= (col_q == 2'd2) ? 2'd0 : col_q + 2'd1;
        end else begin
            slot_q <= slot_q + 1'b1;
        end
    end

    // Accumulate contacts over one scan and classify the result.
    always_comb begin
        hits_now = hits_q;
        if (slot_last) begin
            for (int r = 0; r < 4; r++) begin
                for (int c = 0; c < 3; c++) begin
                    if (!sync2_q[r] && (col_q == 2'(c)))
                        hits_now[r*3+c] = 1'b1;
                end
            end
        end
        hits_d = scan_done ? '0 : hits_now;
        pop = '0;
        idx = '0;
        for (int i = 0; i < 12; i++) begin
            if (hits_now[i]) begin
                pop = pop + 4'd1;
                idx = 4'(i);
            end
        end
        if (pop == 4'd0)      result = NONE;
        else if (pop == 4'd1) result = code_of(idx);
        else                  result = MULTI;
    end

    // Debounce: track how many consecutive scans matched the candidate.
    always_comb begin
        cand_d = cand_q;
        cnt_d  = cnt_q;
        stable = 1'b0;
        if (scan_done) begin
            if (result == cand_q) begin
                if (cnt_q != CW'(DEBOUNCE_SCANS)) begin
                    cnt_d  = cnt_q + 1'b1;
                    stable = (cnt_q == CW'(DEBOUNCE_SCANS - 1));
                end
            end else begin
                cand_d = result;
                cnt_d  = CW'(1);
                stable = (DEBOUNCE_SCANS == 1);
            end
        end
    end

    // Press/release FSM next state and one-cycle emission.
    always_comb begin
        state_d = state_q;
        code_d  = NONE;
        unique case (state_q)
            IDLE: begin
                if (stable && (result < 4'd12)) begin
                    state_d = PRESSED;
                    code_d  = result;
                end
            end
            PRESSED: begin
                if (stable && (result == NONE))
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State, candidate and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            hits_q  <= '0;
            cand_q  <= NONE;
            cnt_q   <= '0;
            code_q  <= NONE;
        end else begin
            state_q <= state_d;
            hits_q  <= hits_d;
            cand_q  <= cand_d;
            cnt_q   <= cnt_d;
            code_q  <= code_d;
        end
    end

    assign kp.col_n    = (col_q == 2'd0) ? 3'b110 :
                         (col_q == 2'd1) ? 3'b101 : 3'b011;
    assign kp.key_code = code_q;
    assign kp.key_held = (state_q == PRESSED);
endmodule

// File: tb/tb_keypad_scanner.sv
// Randomized + directed bench for keypad_scanner with a per-scan
// behavioural model of the keypad, debounce and press tracking.
module tb_keypad_scanner;
    localparam int DB = 3;

    logic        clk = 1'b0;
    logic        clk_en = 1'b0;
    logic        rst = 1'b0;
    logic [11:0] mask = '0;
    logic [3:0]  rows;

    int n_chk  = 0;
    int n_pass = 0;
    int kmap[12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 11, 0, 10};
    int m_prev = 13;
    int m_run  = 0;
    bit m_held = 1'b0;
    int emits[$];

    keypad_scanner_if kp ();

    keypad_scanner #(
        .SCAN_DIV       (4),
        .DEBOUNCE_SCANS (DB)
    ) dut (
        .clk (clk),
        .rst (rst),
        .kp  (kp.slave)
    );

    always begin
        #5;
        if (clk_en) clk = ~clk;
    end

    always_comb begin
        rows = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 3; c++)
                if (kp.col_n[c] == 1'b0 && mask[r*3+c])
                    rows[r] = 1'b0;
    end
    assign kp.row_n = rows;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s got %0d exp %0d", tag, got, exp);
    endtask

    function automatic int scan_result(input logic [11:0] m);
        int n = $countones(m);
        if (n == 0) return 13;
        if (n > 1) return 15;
        for (int i = 0; i < 12; i++)
            if (m[i]) return kmap[i];
        return 13;
    endfunction

    task automatic model_reset();
        m_prev = 13;
        m_run  = 0;
        m_held = 1'b0;
    endtask

    task automatic run_scan(input logic [11:0] m, input int n = 12);
        int res, emit, c;
        mask = m;
        for (int k = 1; k <= n; k++) begin
            @(posedge clk);
            #1;
            emit = 13;
            if (k == 12) begin
                res = scan_result(m);
                if (res == m_prev) m_run++;
                else begin
                    m_prev = res;
                    m_run  = 1;
                end
                if (m_run == DB) begin
                    if (!m_held && res < 12) begin
                        emit   = res;
                        m_held = 1'b1;
                    end else if (m_held && res == 13) begin
                        m_held = 1'b0;
                    end
                end
            end
            c = (k / 4) % 3;
            if (kp.key_code != 4'd13) emits.push_back(int'(kp.key_code));
            chk("key_code", int'(kp.key_code), emit);
            chk("key_held", int'(kp.key_held), int'(m_held));
            chk("col_n", int'(kp.col_n), int'(~(3'b001 << c) & 3'b111));
        end
    endtask

    task automatic scans(input logic [11:0] m, input int cnt);
        for (int i = 0; i < cnt; i++) run_scan(m);
    endtask

    task automatic chk_emits(input string tag, input int exp[$]);
        chk({tag, "_n"}, emits.size(), exp.size());
        for (int i = 0; i < exp.size() && i < emits.size(); i++)
            chk({tag, "_code"}, emits[i], exp[i]);
        emits.delete();
    endtask

    initial begin
        logic [11:0] m;
        int          sel;

        #10 rst = 1'b1;
        #1;
        chk("rst_col", int'(kp.col_n), 6);
        chk("rst_code", int'(kp.key_code), 13);
        chk("rst_held", int'(kp.key_held), 0);
        #9 rst = 1'b0;
        model_reset();
        clk_en = 1'b1;
        scans(12'h000, 2);

        scans(12'h010, 10);
        scans(12'h000, 5);
        chk_emits("single", '{5});

        for (int i = 0; i < 6; i++) run_scan((i % 2 == 0) ? 12'h010 : 12'h000);
        chk_emits("bounce", '{});
        scans(12'h010, 5);
        scans(12'h000, 5);
        chk_emits("bounce_hold", '{5});

        scans(12'h800, 5); scans(12'h000, 5);
        scans(12'h200, 5); scans(12'h000, 5);
        scans(12'h400, 5); scans(12'h000, 5);
        scans(12'h001, 5); scans(12'h000, 5);
        chk_emits("map", '{10, 11, 0, 1});

        scans(12'h101, 5);
        chk_emits("multi", '{});
        scans(12'h100, 5);
        scans(12'h104, 4);
        scans(12'h004, 4);
        scans(12'h000, 4);
        scans(12'h004, 4);
        scans(12'h000, 4);
        chk_emits("roll", '{9, 3});

        scans(12'h080, 4);
        run_scan(12'h080, 5);
        #1 rst = 1'b1;
        #1;
        chk("mid_rst_col", int'(kp.col_n), 6);
        chk("mid_rst_code", int'(kp.key_code), 13);
        chk("mid_rst_held", int'(kp.key_held), 0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
        scans(12'h080, 5);
        scans(12'h000, 5);
        chk_emits("rst_press", '{8, 8});

        m = '0;
        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 1) == 0) begin
                sel = $urandom_range(0, 3);
                if (sel == 0) m = '0;
                else if (sel == 3)
                    m = 12'(1 << $urandom_range(0, 11)) |
                        12'(1 << $urandom_range(0, 11));
                else m = 12'(1 << $urandom_range(0, 11));
            end
            run_scan(m);
        end
        emits.delete();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
